// File: rtl/decode_flags_unit_if.sv
// Decode-stage bus: instruction and ALU flags in, decoded fields and enables out.
interface decode_flags_unit_if;
    logic [31:0] iin;
    logic [3:0]  alu_flags;
    logic [3:0]  alu_opcode_out;
    logic [3:0]  rn_out;
    logic [3:0]  rd_out;
    logic [3:0]  cpsrs_out;
    logic        reg_we;
    logic        mem_we;
    logic        ib;
    logic [31:0] bv;
    logic        bl;
    logic [31:0] cpsr_out;
    logic        ispb;

    // Driver side: supplies the instruction and ALU flags, observes decode results.
    modport master (
        output iin, alu_flags,
        input  alu_opcode_out, rn_out, rd_out, cpsrs_out, reg_we, mem_we,
               ib, bv, bl, cpsr_out, ispb
    );

    // Decode unit side.
    modport slave (
        input  iin, alu_flags,
        output alu_opcode_out, rn_out, rd_out, cpsrs_out, reg_we, mem_we,
               ib, bv, bl, cpsr_out, ispb
    );
endinterface

// File: rtl/decode_flags_unit.sv
// Instruction decode with condition evaluation, CPSR flag register and
// post-branch squash register for the ARM-subset multicycle CPU.
module decode_flags_unit (
    input  logic               clk,
    input  logic               reset,
    decode_flags_unit_if.slave bus
);

    logic [31:0] cpsr_q, cpsr_d;
    logic        ispb_q, ispb_d;

    logic        exec;
    logic [3:0]  opcode;
    logic [3:0]  mask;
    logic        reg_we, mem_we, ib, bl;

    // ARM condition-code test against the registered N,Z,C,V flags.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign opcode = bus.iin[24:21];

    // Class decode: all enables stay low unless the instruction executes.
    always_comb begin
        reg_we = 1'b0;
        mem_we = 1'b0;
        ib     = 1'b0;
        bl     = 1'b0;
        mask   = 4'b0000;
        exec   = cond_pass(bus.iin[31:28], cpsr_q[31:28]) && !ispb_q;
        if (exec) begin
            if (bus.iin[27:26] == 2'b00) begin
                // TST/TEQ/CMP/CMN only set flags; they never write Rd.
                if (opcode[3:2] == 2'b10) begin
                    mask = 4'b1111;
                end else begin
                    reg_we = 1'b1;
                    if (bus.iin[20]) begin
                        // Arithmetic ops produce C and V; logical ops only N and Z.
                        if (opcode >= 4'd2 && opcode <= 4'd7) mask = 4'b1111;
                        else                                  mask = 4'b1100;
                    end
                end
            end else if (bus.iin[27:26] == 2'b01) begin
                if (bus.iin[20]) reg_we = 1'b1;
                else             mem_we = 1'b1;
            end else if (bus.iin[27:25] == 3'b101) begin
                ib = 1'b1;
                bl = bus.iin[24];
            end
        end
    end

    // Next-state for the flag register and squash bit.
    always_comb begin
        cpsr_d = cpsr_q;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) cpsr_d[28+i] = bus.alu_flags[i];
        end
        ispb_d = ib;
    end

    // State registers; reset clears both immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpsr_q <= 32'h0000_0000;
            ispb_q <= 1'b0;
        end else begin
            cpsr_q <= cpsr_d;
            ispb_q <= ispb_d;
        end
    end

    assign bus.alu_opcode_out = opcode;
    assign bus.rn_out         = bus.iin[19:16];
    assign bus.rd_out         = bus.iin[15:12];
    assign bus.cpsrs_out      = mask;
    assign bus.reg_we         = reg_we;
    assign bus.mem_we         = mem_we;
    assign bus.ib             = ib;
    assign bus.bl             = bl;
    // Word offset sign-extended and scaled to bytes; driven even when not taken.
    assign bus.bv             = {{6{bus.iin[23]}}, bus.iin[23:0], 2'b00};
    assign bus.cpsr_out       = cpsr_q;
    assign bus.ispb           = ispb_q;

endmodule

// File: tb/tb_decode_flags_unit.sv
module tb_decode_flags_unit;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  cps;
        logic        reg_we;
        logic        mem_we;
        logic        ib;
        logic        bl;
        logic [31:0] bv;
    } exp_t;

    typedef struct packed {
        logic [31:0] iin;
        logic [3:0]  nzcv;
        exp_t        e;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    decode_flags_unit_if bus ();

    decode_flags_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_exp(input string tag, input exp_t e);
        chk({tag, " op"},     {28'h0, bus.alu_opcode_out}, {28'h0, e.op});
        chk({tag, " rn"},     {28'h0, bus.rn_out},         {28'h0, e.rn});
        chk({tag, " rd"},     {28'h0, bus.rd_out},         {28'h0, e.rd});
        chk({tag, " cpsrs"},  {28'h0, bus.cpsrs_out},      {28'h0, e.cps});
        chk({tag, " reg_we"}, {31'h0, bus.reg_we},         {31'h0, e.reg_we});
        chk({tag, " mem_we"}, {31'h0, bus.mem_we},         {31'h0, e.mem_we});
        chk({tag, " ib"},     {31'h0, bus.ib},             {31'h0, e.ib});
        chk({tag, " bl"},     {31'h0, bus.bl},             {31'h0, e.bl});
        chk({tag, " bv"},     bus.bv,                      e.bv);
    endtask

    // Reference model: decode outcome from the ARM rules, given flags and squash state.
    function automatic exp_t model(input logic [31:0] ins, input logic [3:0] nzcv, input logic sq);
        exp_t        e;
        logic        n, z, c, v, pass, base;
        int          cond, op;
        logic [31:0] off;
        n = nzcv[3]; z = nzcv[2]; c = nzcv[1]; v = nzcv[0];
        cond = int'(ins[31:28]);
        op   = int'(ins[24:21]);
        // Even codes test a predicate, the following odd code is its negation.
        case (cond / 2)
            0:       base = z;
            1:       base = c;
            2:       base = n;
            3:       base = v;
            4:       base = c & ~z;
            5:       base = (n == v);
            default: base = ~z & (n == v);
        endcase
        if (cond == 14)      pass = 1'b1;
        else if (cond == 15) pass = 1'b0;
        else                 pass = base ^ ins[28];
        off = {8'h00, ins[23:0]};
        if (ins[23]) off = off - 32'h0100_0000;
        e        = '0;
        e.op     = ins[24:21];
        e.rn     = ins[19:16];
        e.rd     = ins[15:12];
        e.bv     = off * 4;
        if (pass && !sq) begin
            if (ins[27:26] == 2'b00) begin
                if (op >= 8 && op <= 11) e.cps = 4'b1111;
                else begin
                    e.reg_we = 1'b1;
                    if (ins[20]) e.cps = (op >= 2 && op <= 7) ? 4'b1111 : 4'b1100;
                end
            end else if (ins[27:26] == 2'b01) begin
                if (ins[20]) e.reg_we = 1'b1;
                else         e.mem_we = 1'b1;
            end else if (ins[27:25] == 3'b101) begin
                e.ib = 1'b1;
                e.bl = ins[24];
            end
        end
        return e;
    endfunction

    // One clock of a never-executing instruction, so the squash bit is clear afterwards.
    task automatic idle();
        @(negedge clk);
        bus.iin = 32'hF000_0000;
        @(posedge clk);
    endtask

    // Load the CPSR flags through an always-executing CMP.
    task automatic set_flags(input logic [3:0] nzcv);
        idle();
        @(negedge clk);
        bus.iin       = 32'hE151_0002;
        bus.alu_flags = nzcv;
        @(posedge clk);
        #1;
        chk("set_flags cpsr", bus.cpsr_out, {nzcv, 28'h0});
    endtask

    vec_t        vecs[14];
    exp_t        e;
    logic [3:0]  m_nzcv;
    logic        m_ispb;
    logic [31:0] r;
    logic [3:0]  fl;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.iin       = 32'hF000_0000;
        bus.alu_flags = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset with a pending branch and non-zero flags.
        set_flags(4'b1111);
        @(negedge clk);
        bus.iin = 32'hEA00_0000;
        @(posedge clk);
        #1;
        chk("pre-reset ispb", {31'h0, bus.ispb}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("reset cpsr", bus.cpsr_out, 32'h0);
        chk("reset ispb", {31'h0, bus.ispb}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post-reset cpsr", bus.cpsr_out, 32'h0);
        chk("post-reset ispb", {31'h0, bus.ispb}, 32'd0);

        // ADDS updates all flags from the ALU.
        idle();
        @(negedge clk);
        bus.iin       = 32'hE091_2003;
        bus.alu_flags = 4'b0100;
        #1;
        check_exp("adds", '{4'd4, 4'd1, 4'd2, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFE44_800C});
        @(posedge clk);
        #1;
        chk("adds cpsr", bus.cpsr_out, 32'h4000_0000);

        // Table of decode vectors, each with its own preset flags.
        vecs[0]  = '{32'h1A00_0004, 4'b0100, '{4'h0, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010}};
        vecs[1]  = '{32'h1A00_0004, 4'b0000, '{4'h0, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010}};
        vecs[2]  = '{32'hEBFF_FFFE, 4'b0000, '{4'hF, 4'hF, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8}};
        vecs[3]  = '{32'hE581_2000, 4'b0000, '{4'hC, 4'h1, 4'h2, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFE04_8000}};
        vecs[4]  = '{32'hE591_2000, 4'b0000, '{4'hC, 4'h1, 4'h2, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFE44_8000}};
        vecs[5]  = '{32'hE151_0002, 4'b0000, '{4'hA, 4'h1, 4'h0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0144_0008}};
        vecs[6]  = '{32'hE3A0_1005, 4'b0000, '{4'hD, 4'h0, 4'h1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFE80_4014}};
        vecs[7]  = '{32'hE3B0_1005, 4'b0000, '{4'hD, 4'h0, 4'h1, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFEC0_4014}};
        vecs[8]  = '{32'hC081_2003, 4'b1001, '{4'h4, 4'h1, 4'h2, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFE04_800C}};
        vecs[9]  = '{32'hC081_2003, 4'b1000, '{4'h4, 4'h1, 4'h2, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFE04_800C}};
        vecs[10] = '{32'hF081_2003, 4'b0000, '{4'h4, 4'h1, 4'h2, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFE04_800C}};
        vecs[11] = '{32'hEC00_0000, 4'b0000, '{4'h0, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000}};
        vecs[12] = '{32'h8081_2003, 4'b0010, '{4'h4, 4'h1, 4'h2, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFE04_800C}};
        vecs[13] = '{32'h9081_2003, 4'b0010, '{4'h4, 4'h1, 4'h2, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFE04_800C}};
        for (int i = 0; i < 14; i++) begin
            set_flags(vecs[i].nzcv);
            @(negedge clk);
            bus.iin       = vecs[i].iin;
            bus.alu_flags = 4'h0;
            #1;
            check_exp($sformatf("vec%0d", i), vecs[i].e);
        end

        // Taken branch squashes exactly the next instruction.
        idle();
        @(negedge clk);
        bus.iin = 32'hEA00_0000;
        @(posedge clk);
        @(negedge clk);
        bus.iin = 32'hE3A0_1005;
        #1;
        chk("squash ispb", {31'h0, bus.ispb}, 32'd1);
        check_exp("squash mov", '{4'hD, 4'h0, 4'h1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFE80_4014});
        @(posedge clk);
        #1;
        chk("unsquash ispb", {31'h0, bus.ispb}, 32'd0);
        check_exp("unsquash mov", '{4'hD, 4'h0, 4'h1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFE80_4014});

        // Randomized run against the reference model from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset  = 1'b0;
        m_nzcv = 4'h0;
        m_ispb = 1'b0;
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: r[27:26] = 2'b00;
                1: r[27:26] = 2'b01;
                2: r[27:25] = 3'b101;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) r[31:28] = 4'hE;
            fl = 4'($urandom);
            @(negedge clk);
            bus.iin       = r;
            bus.alu_flags = fl;
            #1;
            e = model(r, m_nzcv, m_ispb);
            check_exp($sformatf("rnd%0d", k), e);
            chk($sformatf("rnd%0d cpsr", k), bus.cpsr_out, {m_nzcv, 28'h0});
            chk($sformatf("rnd%0d ispb", k), {31'h0, bus.ispb}, {31'h0, m_ispb});
            @(posedge clk);
            for (int b = 0; b < 4; b++) if (e.cps[b]) m_nzcv[b] = fl[b];
            m_ispb = e.ib;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
